dccm_dma_arb: RTL and testbench

Arbiter and sequencer for the single DCCM port shared between the load/store unit (LSU) and the DMA slave. Core requests have fixed priority, with a bounded-wait override so DMA cannot starve. The block registers the winning request onto the DCCM port and routes read data back to its owner. It also drains and freezes the port on a refresh-PC/freeze request, so the pipeline can resynchronise with no DCCM access in flight.

---
 rtl/dccm_arb_pkg.sv | 19 +
 rtl/dccm_arb_starve_ctr.sv | 31 +++
 rtl/dccm_dma_arb.sv | 118 +++++++++++
 tb/tb_dccm_dma_arb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dccm_arb_pkg.sv
// Shared types and defaults for the DCCM LSU/DMA port arbiter.
// Consumed by dccm_dma_arb and dccm_arb_starve_ctr.
package dccm_arb_pkg;

  localparam int DMA_MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    FROZEN
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_LSU,
    OWN_DMA
  } owner_e;

endpackage

// File: rtl/dccm_arb_starve_ctr.sv
// Saturating count of consecutive blocked DMA cycles.
// force_dma rises once the DMA has waited DMA_MAX_WAIT cycles.
module dccm_arb_starve_ctr
  import dccm_arb_pkg::*;
#(
  parameter int DMA_MAX_WAIT = DMA_MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic force_dma
);

  localparam logic [3:0] MAXW = 4'(DMA_MAX_WAIT);

  logic [3:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!dma_req || dma_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAXW) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign force_dma = (wait_cnt == MAXW);

endmodule

// File: rtl/dccm_dma_arb.sv
// DCCM port arbiter: LSU priority, bounded DMA wait, freeze/drain.
// Optional statistics counters enabled by DCCM_ARB_STATS_EN.
module dccm_dma_arb
  import dccm_arb_pkg::*;
#(
  parameter int AW           = 16,
  parameter int DW           = 32,
  parameter int DMA_MAX_WAIT = DMA_MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lsu_req,
  input  logic          lsu_we,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_wdata,
  output logic          lsu_gnt,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dccm_req,
  output logic          dccm_we,
  output logic [AW-1:0] dccm_addr,
  output logic [DW-1:0] dccm_wdata,
  input  logic [DW-1:0] dccm_rdata,
  output logic [DW-1:0] rdata,
  output logic          lsu_rvalid,
  output logic          dma_rvalid,
  input  logic          freeze_req,
  output logic          freeze_ack,
  output logic [15:0]   stat_dma_gnt_cnt,
  output logic [15:0]   stat_dma_stall_cnt
);

  arb_state_e state;
  owner_e     req_owner;
  owner_e     rv_owner;
  logic       grant_ok;
  logic       force_dma;

  dccm_arb_starve_ctr #(
    .DMA_MAX_WAIT(DMA_MAX_WAIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .dma_req  (dma_req),
    .dma_gnt  (dma_gnt),
    .force_dma(force_dma)
  );

  // FROZEN may grant in the cycle freeze_req drops; DRAIN never grants.
  assign grant_ok = !rst && !freeze_req && (state != DRAIN);
  assign dma_gnt  = grant_ok && dma_req && (force_dma || !lsu_req);
  assign lsu_gnt  = grant_ok && lsu_req && !dma_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      dccm_req   <= 1'b0;
      dccm_we    <= 1'b0;
      dccm_addr  <= '0;
      dccm_wdata <= '0;
      req_owner  <= OWN_NONE;
      rv_owner   <= OWN_NONE;
    end else begin
      dccm_req <= lsu_gnt || dma_gnt;
      if (dma_gnt) begin
        dccm_we    <= dma_we;
        dccm_addr  <= dma_addr;
        dccm_wdata <= dma_wdata;
        req_owner  <= OWN_DMA;
      end else if (lsu_gnt) begin
        dccm_we    <= lsu_we;
        dccm_addr  <= lsu_addr;
        dccm_wdata <= lsu_wdata;
        req_owner  <= OWN_LSU;
      end
      rv_owner <= (dccm_req && !dccm_we) ? req_owner : OWN_NONE;
      unique case (state)
        RUN: begin
          if (freeze_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!freeze_req) state <= RUN;
          else if (!dccm_req) state <= FROZEN;
        end
        FROZEN: begin
          if (!freeze_req) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign rdata      = dccm_rdata;
  assign lsu_rvalid = (rv_owner == OWN_LSU);
  assign dma_rvalid = (rv_owner == OWN_DMA);
  assign freeze_ack = (state == FROZEN) && freeze_req;

`ifdef DCCM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_dma_gnt_cnt   <= '0;
      stat_dma_stall_cnt <= '0;
    end else begin
      if (dma_gnt && stat_dma_gnt_cnt != 16'hFFFF)
        stat_dma_gnt_cnt <= stat_dma_gnt_cnt + 16'd1;
      if (dma_req && !dma_gnt && stat_dma_stall_cnt != 16'hFFFF)
        stat_dma_stall_cnt <= stat_dma_stall_cnt + 16'd1;
    end
  end
`else
  assign stat_dma_gnt_cnt   = '0;
  assign stat_dma_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dccm_dma_arb.sv
// Self-checking bench for dccm_dma_arb against a cycle-level reference model.
// Define DCCM_ARB_STATS_EN to expect live statistics counters.
module tb_dccm_dma_arb;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          lsu_req, lsu_we;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic          lsu_gnt;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dccm_req, dccm_we;
  logic [AW-1:0] dccm_addr;
  logic [DW-1:0] dccm_wdata;
  logic [DW-1:0] dccm_rdata;
  logic [DW-1:0] rdata;
  logic          lsu_rvalid, dma_rvalid;
  logic          freeze_req, freeze_ack;
  logic [15:0]   stat_dma_gnt_cnt, stat_dma_stall_cnt;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model: mode 0 running, 1 draining, 2 frozen
  int            m_mode, m_wait, m_own, m_rv, m_sg, m_ss;
  bit            m_dreq, m_dwe;
  logic [AW-1:0] m_daddr;
  logic [DW-1:0] m_dwdata;

  dccm_dma_arb #(
    .AW(AW), .DW(DW), .DMA_MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst(rst),
    .lsu_req(lsu_req), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lsu_gnt),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt),
    .dccm_req(dccm_req), .dccm_we(dccm_we),
    .dccm_addr(dccm_addr), .dccm_wdata(dccm_wdata),
    .dccm_rdata(dccm_rdata), .rdata(rdata),
    .lsu_rvalid(lsu_rvalid), .dma_rvalid(dma_rvalid),
    .freeze_req(freeze_req), .freeze_ack(freeze_ack),
    .stat_dma_gnt_cnt(stat_dma_gnt_cnt),
    .stat_dma_stall_cnt(stat_dma_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_own = 0; m_rv = 0;
    m_sg = 0; m_ss = 0; m_dreq = 0; m_dwe = 0;
    m_daddr = '0; m_dwdata = '0;
  endtask

  // One clock: apply inputs, check at negedge, advance model at posedge.
  task automatic cyc(input bit r, input bit fr,
                     input bit lr, input bit lw,
                     input logic [AW-1:0] la, input logic [DW-1:0] ld,
                     input bit dr, input bit dw,
                     input logic [AW-1:0] da, input logic [DW-1:0] dd);
    bit ok, eg_d, eg_l;
    int n_mode;
    rst = r; freeze_req = fr;
    lsu_req = lr; lsu_we = lw; lsu_addr = la; lsu_wdata = ld;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    dccm_rdata = $urandom;
    ok   = !r && !fr && (m_mode != 1);
    eg_d = ok && dr && (m_wait == MAXW || !lr);
    eg_l = ok && lr && !eg_d;
    @(negedge clk);
    chk("lsu_gnt", 32'(lsu_gnt), 32'(eg_l));
    chk("dma_gnt", 32'(dma_gnt), 32'(eg_d));
    chk("dccm_req", 32'(dccm_req), 32'(m_dreq));
    chk("dccm_we", 32'(dccm_we), 32'(m_dwe));
    chk("dccm_addr", 32'(dccm_addr), 32'(m_daddr));
    chk("dccm_wdata", dccm_wdata, m_dwdata);
    chk("lsu_rvalid", 32'(lsu_rvalid), 32'(m_rv == 1));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(m_rv == 2));
    chk("rdata", rdata, dccm_rdata);
    chk("freeze_ack", 32'(freeze_ack), 32'(m_mode == 2 && fr));
`ifdef DCCM_ARB_STATS_EN
    chk("stat_gnt", 32'(stat_dma_gnt_cnt), 32'(m_sg));
    chk("stat_stall", 32'(stat_dma_stall_cnt), 32'(m_ss));
`else
    chk("stat_gnt", 32'(stat_dma_gnt_cnt), 32'(0));
    chk("stat_stall", 32'(stat_dma_stall_cnt), 32'(0));
`endif
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      n_mode = m_mode;
      if (m_mode == 0 && fr) n_mode = 1;
      if (m_mode == 1) n_mode = !fr ? 0 : (!m_dreq ? 2 : 1);
      if (m_mode == 2 && !fr) n_mode = 0;
      m_mode = n_mode;
      m_rv   = (m_dreq && !m_dwe) ? m_own : 0;
      m_dreq = eg_d || eg_l;
      if (eg_d) begin
        m_dwe = dw; m_daddr = da; m_dwdata = dd; m_own = 2;
      end else if (eg_l) begin
        m_dwe = lw; m_daddr = la; m_dwdata = ld; m_own = 1;
      end
      m_wait = (dr && !eg_d) ? ((m_wait < MAXW) ? m_wait + 1 : MAXW) : 0;
      if (eg_d && m_sg < 16'hFFFF) m_sg++;
      if (dr && !eg_d && m_ss < 16'hFFFF) m_ss++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    bit fz;
    model_reset();
    // reset: all outputs zero
    cyc(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);
    cyc(1, 0, 1, 0, 16'h1, 32'h5, 1, 1, 16'h2, 32'h6);
    idle(1);

    // LSU-only read of 0x0010
    cyc(0, 0, 1, 0, 16'h0010, 32'h0, 0, 0, '0, '0);
    idle(3);

    // contention: DMA forced every 5th cycle
    for (int i = 0; i < 12; i++)
      cyc(0, 0, 1, 0, 16'(i), 32'(i), 1, 0, 16'h200 + 16'(i), 32'h0);
    idle(2);

    // DMA write while idle
    cyc(0, 0, 0, 0, '0, '0, 1, 1, 16'h0100, 32'hDEADBEEF);
    idle(3);

    // freeze after an LSU read; release in cycle 6 with LSU pending
    cyc(0, 0, 1, 0, 16'h0044, 32'h0, 0, 0, '0, '0);
    for (int i = 1; i < 6; i++)
      cyc(0, 1, 1, 0, 16'h0048, 32'h0, 0, 0, '0, '0);
    cyc(0, 0, 1, 0, 16'h0048, 32'h0, 0, 0, '0, '0);
    idle(3);

    // reset in the cycle after a read grant
    cyc(0, 0, 1, 0, 16'h0077, 32'h0, 1, 0, 16'h0099, 32'h0);
    cyc(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);
    idle(3);

    // statistics: 3 DMA grants, then 5 stalled cycles under freeze
    cyc(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, '0, '0, 1, 1, 16'h300 + 16'(i), 32'(i));
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 0, 0, '0, '0, 1, 0, 16'h400, 32'h0);
`ifdef DCCM_ARB_STATS_EN
    chk("stat_gnt_3", 32'(stat_dma_gnt_cnt), 32'd3);
    chk("stat_stall_5", 32'(stat_dma_stall_cnt), 32'd5);
`else
    chk("stat_gnt_off", 32'(stat_dma_gnt_cnt), 32'd0);
    chk("stat_stall_off", 32'(stat_dma_stall_cnt), 32'd0);
`endif
    idle(3);

    // randomized traffic with freeze bursts and occasional reset
    fz = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) fz = !fz;
      cyc($urandom_range(0, 59) == 0, fz,
          $urandom_range(0, 9) < 6, 1'($urandom),
          16'($urandom), $urandom,
          $urandom_range(0, 9) < 5, 1'($urandom),
          16'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
